// File: rtl/cos_rom_arbiter_pkg.sv
// Shared definitions for the cos_rom lookup arbiter in the Calc_G datapath.
// Holds the cos_rom geometry (address/data width, read latency) that both
// cos_rom and the arbiter are sized from, plus the round-robin pointer helper.
package cos_rom_arbiter_pkg;

    localparam int COS_ADDR_W  = 12;
    localparam int COS_DATA_W  = 16;
    localparam int COS_ROM_LAT = 1;

    // Next round-robin start position after index idx, wrapping at n.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cos_rsp_fifo.sv
// Response FIFO for cos_rom_arbiter: synchronous, single clock, first-word
// fall-through head.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   push        write push_data this cycle
//   push_data   {id, rom data} entry
//   pop         drop the head entry this cycle
//   head        current oldest entry (undefined content when empty)
//   empty       no entries stored
//   count       number of stored entries (0..DEPTH)
module cos_rsp_fifo
    import cos_rom_arbiter_pkg::*;
#(
    parameter  int W     = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // The upstream credit rule must make a push into a full FIFO impossible.
            if (push) begin
                assert (count_q != CW'(DEPTH));
            end
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/cos_rom_arbiter.sv
// Shares one cos_rom lookup port between N_REQ angle-generating requesters.
// Round-robin grant, at most one ROM access per cycle; ROM data plus the
// requester index return through a credit-protected response FIFO.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   req_valid   per-requester request valid
//   req_addr    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready   one-hot grant (handshake on valid & ready)
//   rom_addr    address to cos_rom, granted requester's address or 0
//   rom_out     cos_rom data, ROM_LAT cycles after rom_addr is sampled
//   rsp_valid   response available
//   rsp_ready   consumer accepts the response
//   rsp_id      index of the requester that issued the response (0 when empty)
//   rsp_data    ROM data for that request (0 when empty)
module cos_rom_arbiter
    import cos_rom_arbiter_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int ADDR_W     = COS_ADDR_W,
    parameter  int DATA_W     = COS_DATA_W,
    parameter  int ROM_LAT    = COS_ROM_LAT,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = ID_W + DATA_W;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ROM_LAT-1:0] pipe_vld_q;
    logic [ID_W-1:0]    pipe_id_q [ROM_LAT];

    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic               can_issue;
    int                 inflight;
    int                 scan_idx;

    logic               fifo_push;
    logic [FW-1:0]      fifo_push_data;
    logic               fifo_pop;
    logic [FW-1:0]      fifo_head;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;

    // Credit: every queued entry and every ROM read still in flight owns a
    // FIFO slot; a pop this cycle releases one slot to a grant this cycle.
    always_comb begin
        inflight = 0;
        for (int s = 0; s < ROM_LAT; s++) begin
            if (pipe_vld_q[s]) inflight = inflight + 1;
        end
        can_issue = (int'(fifo_count) + inflight - int'(fifo_pop)) < FIFO_DEPTH;
    end

    // Round-robin search starting at rr_ptr_q; no grant is given while in reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(scan_idx);
            end
        end
        grant_vld = grant_vld & can_issue & rst_n;
    end

    assign req_ready = grant_vld ? (N_REQ'(1) << grant_id) : '0;
    assign rom_addr  = grant_vld ? req_addr[int'(grant_id)*ADDR_W +: ADDR_W] : '0;
    assign rr_ptr_d  = grant_vld ? ID_W'(rr_wrap_inc(32'(grant_id), 32'(N_REQ))) : rr_ptr_q;

    // Issue stage: grant -> ROM read in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            pipe_vld_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            pipe_vld_q[0] <= grant_vld;
            for (int s = 1; s < ROM_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_id_q[0] <= grant_id;
        for (int s = 1; s < ROM_LAT; s++) begin
            pipe_id_q[s] <= pipe_id_q[s-1];
        end
    end

    // Return stage: ROM data lands in the response FIFO
    assign fifo_push      = pipe_vld_q[ROM_LAT-1];
    assign fifo_push_data = {pipe_id_q[ROM_LAT-1], rom_out};
    assign fifo_pop       = rsp_valid & rsp_ready;

    cos_rsp_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_empty ? '0 : fifo_head[DATA_W +: ID_W];
    assign rsp_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

endmodule
